// File: rtl/mux_key.sv
// mux_key: key-lookup multiplexer over a packed table of {key, data} pairs.
// Drives the data of the lowest-index matching pair (zero on no match) on a
// combinational path, and a registered copy with hit/multi status.
module mux_key #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit,
    output logic                                 multi,
    output logic [DATA_LEN-1:0]                  out_q,
    output logic                                 hit_q,
    output logic                                 multi_q
);

    localparam int P = KEY_LEN + DATA_LEN;

    // Unpacked view of the table: entry i sits at lut[P*(i+1)-1 : P*i],
    // key in the upper KEY_LEN bits, data in the lower DATA_LEN bits.
    logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
    logic [DATA_LEN-1:0] ent_data [NR_KEY];
    logic [NR_KEY-1:0]   match;

    for (genvar g = 0; g < NR_KEY; g++) begin : g_entry
        assign ent_key[g]  = lut[P*g+DATA_LEN +: KEY_LEN];
        assign ent_data[g] = lut[P*g +: DATA_LEN];
        assign match[g]    = (ent_key[g] == key);
    end

    logic [DATA_LEN-1:0] out_d;
    logic                hit_d;
    logic                multi_d;

    // Priority select: walk from the top entry down so the lowest-index match
    // is the last writer; a second match on the way raises multi.
    always_comb begin
        out_d   = '0;
        hit_d   = 1'b0;
        multi_d = 1'b0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (match[i]) begin
                if (hit_d) begin
                    multi_d = 1'b1;
                end
                hit_d = 1'b1;
                out_d = ent_data[i];
            end
        end
    end

    assign out   = out_d;
    assign hit   = hit_d;
    assign multi = multi_d;

    // Pipelined copy: capture every cycle, synchronous active-low clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            hit_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            hit_q   <= hit_d;
            multi_q <= multi_d;
        end
    end

endmodule

// File: tb/tb_mux_key.sv
// Directed bench for mux_key across four table shapes sharing one clock/reset.
module tb_mux_key;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4 entries, 2-bit key, 8-bit data
    logic [1:0]  key4;
    logic [39:0] lut4;
    logic [7:0]  out4, out4_q;
    logic        hit4, multi4, hit4_q, multi4_q;

    // 5 entries, 3-bit key, 32-bit data
    logic [2:0]   key5;
    logic [174:0] lut5;
    logic [31:0]  out5, out5_q;
    logic         hit5, multi5, hit5_q, multi5_q;

    // 2 entries, 1-bit key, 4-bit data (duplicate keys)
    logic [0:0] key2;
    logic [9:0] lut2;
    logic [3:0] out2, out2_q;
    logic       hit2, multi2, hit2_q, multi2_q;

    // 1 entry, 2-bit key, 8-bit data
    logic [1:0] key1;
    logic [9:0] lut1;
    logic [7:0] out1, out1_q;
    logic       hit1, multi1, hit1_q, multi1_q;

    mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u4 (
        .clk(clk), .rst_n(rst_n), .key(key4), .lut(lut4),
        .out(out4), .hit(hit4), .multi(multi4),
        .out_q(out4_q), .hit_q(hit4_q), .multi_q(multi4_q)
    );
    mux_key #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32)) u5 (
        .clk(clk), .rst_n(rst_n), .key(key5), .lut(lut5),
        .out(out5), .hit(hit5), .multi(multi5),
        .out_q(out5_q), .hit_q(hit5_q), .multi_q(multi5_q)
    );
    mux_key #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(4)) u2 (
        .clk(clk), .rst_n(rst_n), .key(key2), .lut(lut2),
        .out(out2), .hit(hit2), .multi(multi2),
        .out_q(out2_q), .hit_q(hit2_q), .multi_q(multi2_q)
    );
    mux_key #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(8)) u1 (
        .clk(clk), .rst_n(rst_n), .key(key1), .lut(lut1),
        .out(out1), .hit(hit1), .multi(multi1),
        .out_q(out1_q), .hit_q(hit1_q), .multi_q(multi1_q)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference tables indexed by key code (zero = no entry for that code)
    logic [7:0]  exp4 [4];
    logic [31:0] exp5 [8];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp4[0] = 8'hA1; exp4[1] = 8'hB2; exp4[2] = 8'hC3; exp4[3] = 8'hD4;
        exp5[0] = 32'h0000_00A0; exp5[1] = 32'h1111_00B1; exp5[2] = 32'h2222_00C2;
        exp5[3] = 32'h0;         exp5[4] = 32'h4444_00D4; exp5[5] = 32'h5555_00E5;
        exp5[6] = 32'h0;         exp5[7] = 32'h0;

        lut4 = {2'b00, 8'hA1, 2'b01, 8'hB2, 2'b10, 8'hC3, 2'b11, 8'hD4};
        lut5 = {3'b000, 32'h0000_00A0, 3'b001, 32'h1111_00B1, 3'b010, 32'h2222_00C2,
                3'b100, 32'h4444_00D4, 3'b101, 32'h5555_00E5};
        lut2 = {1'b1, 4'h5, 1'b1, 4'hA};
        lut1 = {2'b10, 8'h5A};
        key4 = 2'd2; key5 = 3'b100; key2 = 1'b1; key1 = 2'b10;

        // Reset held for two edges: registers clear, combinational path live
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        check("rst out4_q",   32'(out4_q),   32'h0);
        check("rst hit4_q",   32'(hit4_q),   32'h0);
        check("rst multi4_q", 32'(multi4_q), 32'h0);
        check("rst out5_q",   out5_q,        32'h0);
        check("rst multi2_q", 32'(multi2_q), 32'h0);
        check("rst out4 comb", 32'(out4),    32'hC3);
        check("rst hit4 comb", 32'(hit4),    32'h1);
        check("rst multi2 comb", 32'(multi2), 32'h1);

        // Release: capture resumes on the next edge
        rst_n = 1'b1;
        next_cycle();
        check("rel out4_q",   32'(out4_q),   32'hC3);
        check("rel hit4_q",   32'(hit4_q),   32'h1);
        check("rel out5_q",   out5_q,        32'h4444_00D4);
        check("rel out2_q",   32'(out2_q),   32'hA);
        check("rel multi2_q", 32'(multi2_q), 32'h1);
        check("rel out1_q",   32'(out1_q),   32'h5A);

        // Sweep all keys of the full 4-entry table
        for (int k = 0; k < 4; k++) begin
            key4 = 2'(k);
            #1;
            check("sweep out4",   32'(out4),   32'(exp4[k]));
            check("sweep hit4",   32'(hit4),   32'h1);
            check("sweep multi4", 32'(multi4), 32'h0);
            next_cycle();
            check("sweep out4_q", 32'(out4_q), 32'(exp4[k]));
            check("sweep hit4_q", 32'(hit4_q), 32'h1);
        end

        // Unused key codes on the 5-entry table return zero
        key5 = 3'b011;
        #1;
        check("gap011 out5", out5, 32'h0);
        check("gap011 hit5", 32'(hit5), 32'h0);
        key5 = 3'b110;
        #1;
        check("gap110 out5", out5, 32'h0);
        check("gap110 hit5", 32'(hit5), 32'h0);
        next_cycle();
        check("gap110 hit5_q", 32'(hit5_q), 32'h0);
        key5 = 3'b101;
        #1;
        check("key101 out5", out5, 32'h5555_00E5);

        // Duplicate keys: lowest-index entry wins; the other key misses
        key2 = 1'b1;
        #1;
        check("dup out2",   32'(out2),   32'hA);
        check("dup hit2",   32'(hit2),   32'h1);
        check("dup multi2", 32'(multi2), 32'h1);
        key2 = 1'b0;
        #1;
        check("dup miss out2",   32'(out2),   32'h0);
        check("dup miss hit2",   32'(hit2),   32'h0);
        check("dup miss multi2", 32'(multi2), 32'h0);
        next_cycle();
        check("dup miss multi2_q", 32'(multi2_q), 32'h0);

        // Key changes every cycle: registered output lags the lookup by one
        for (int n = 0; n < 24; n++) begin
            logic [1:0] k4;
            logic [2:0] k5;
            k4 = 2'($urandom_range(0, 3));
            k5 = 3'($urandom_range(0, 7));
            key4 = k4;
            key5 = k5;
            #1;
            check("rand out4", 32'(out4), 32'(exp4[k4]));
            check("rand out5", out5, exp5[k5]);
            check("rand hit5", 32'(hit5), 32'(exp5[k5] != 32'h0));
            next_cycle();
            check("rand out4_q", 32'(out4_q), 32'(exp4[k4]));
            check("rand out5_q", out5_q, exp5[k5]);
            check("rand hit5_q", 32'(hit5_q), 32'(exp5[k5] != 32'h0));
        end

        // Table contents change under a held key: output follows immediately
        key4 = 2'b01;
        lut4 = {2'b00, 8'hA1, 2'b01, 8'h3C, 2'b10, 8'hC3, 2'b11, 8'hD4};
        #1;
        check("lutchg out4", 32'(out4), 32'h3C);
        lut4 = {2'b00, 8'hA1, 2'b11, 8'h3C, 2'b10, 8'hC3, 2'b11, 8'hD4};
        #1;
        check("lutchg gone out4", 32'(out4), 32'h0);
        check("lutchg gone hit4", 32'(hit4), 32'h0);
        key4 = 2'b11;
        #1;
        check("lutchg dup out4",   32'(out4),   32'hD4);
        check("lutchg dup multi4", 32'(multi4), 32'h1);

        // Single-entry table
        key1 = 2'b01;
        #1;
        check("one miss out1", 32'(out1), 32'h0);
        check("one miss hit1", 32'(hit1), 32'h0);
        key1 = 2'b10;
        #1;
        check("one hit out1",   32'(out1),   32'h5A);
        check("one hit multi1", 32'(multi1), 32'h0);

        // Mid-stream reset pulse on a single edge
        rst_n = 1'b0;
        next_cycle();
        check("pulse out1_q", 32'(out1_q), 32'h0);
        check("pulse out1",   32'(out1),   32'h5A);
        rst_n = 1'b1;
        next_cycle();
        check("pulse rel out1_q", 32'(out1_q), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
